bsg_round_robin_burst_n_to_1: RTL
=================================

// Module: bsg_round_robin_burst_n_to_1
// PURPOSE
//  Packet-aware round-robin N-to-1 arbiter and mux for a shared valid/yumi output channel.
//  - A grant is held for a whole multi-beat packet, delimited by last_i.
//  - A requester may keep its grant for up to max_pkts_p back-to-back packets.
//  - Sits in front of a shared link or fifo where single-beat round-robin would interleave packets.
// PARAMETERS
//  width_p     16  data width per input, in bits
//  num_in_p     2  number of requesters; 2..16
//  max_pkts_p   2  max consecutive packets per tenure; >=1 (1 = packet-granular round-robin)
//  lg_in_lp   $clog2(num_in_p)  localparam; width of tag_o and owner_r
// PORTS
//  clk_i      in   1                 clock; all state updates on posedge
//  reset_n_i  in   1                 asynchronous active-low reset
//  data_i     in   num_in_p*width_p  input j occupies bits [j*width_p +: width_p]
//  v_i        in   num_in_p          per-input valid
//  last_i     in   num_in_p          per-input last-beat-of-packet flag, qualified by v_i
//  yumi_o     out  num_in_p          per-input dequeue; one-hot or zero
//  v_o        out  1                 output valid
//  data_o     out  width_p           data of the selected input
//  tag_o      out  lg_in_lp          index of the selected input
//  last_o     out  1                 last_i of the selected input
//  yumi_i     in   1                 consumer accept; legal only while v_o=1
// BEHAVIOUR
//  State registers (async cleared by reset_n_i=0)
//  - owner_r = num_in_p-1, so input 0 has top priority after reset
//  - tenure_r = 0, mid_pkt_r = 0, pkts_r = 0
//  Selection (combinational, no bubbles)
//  - Forced mode, when mid_pkt_r=1: sel = owner_r; v_o = v_i[owner_r].
//    Other inputs are blocked even when owner_r is idle.
//  - Hold mode, when mid_pkt_r=0 & tenure_r & v_i[owner_r] & pkts_r<max_pkts_p:
//    sel = owner_r; v_o = 1.
//  - Round-robin mode, otherwise: sel = first j with v_i[j], scanning circularly from owner_r+1.
//    owner_r itself has lowest priority. v_o = |v_i.
//    If v_i=0, then v_o=0 and tag_o/data_o are don't-care.
//  Outputs
//  - data_o, tag_o and last_o are always driven from sel.
//  - yumi_o[sel] = yumi_i & v_o; all other yumi_o bits are 0.
//  Outputs during reset
//  - Outputs are combinational, so they follow v_i using round-robin mode from input 0.
//  - yumi_o stays 0 unless yumi_i=1.
//  Update on handshake (v_o & yumi_i)
//  - owner_r <= sel; tenure_r <= 1; mid_pkt_r <= ~last_i[sel].
//  - new_tenure = (sel != owner_r) | ~tenure_r | round-robin mode.
//  - If last_i[sel]: pkts_r <= new_tenure ? 1 : pkts_r+1. Saturates at max_pkts_p.
//  - If not last_i[sel] and new_tenure: pkts_r <= 0.
//  No handshake: state holds.
//  Boundary cases
//  - A single-beat packet (last_i=1 on the first beat) counts as 1 packet.
//  - Hold mode releases in the same cycle that v_i[owner_r] falls at a packet boundary; no idle cycle.
//  - pkts_r==max_pkts_p forces round-robin mode. The owner may still win if it is the only requester,
//    which starts a new tenure.
//  - Reset mid-packet abandons the packet; no recovery is attempted.
//  - yumi_i while v_o=0: illegal; assertion fires in simulation.
// CONFIGURATION
//  BSG_ROUND_ROBIN_BURST_STALL_WATCHDOG_EN
//  - Defined:
//    - Adds parameter stall_limit_p (default 64) and output port stall_o (1 bit).
//    - A counter tracks consecutive cycles with mid_pkt_r & ~v_i[owner_r]; it clears on any other cycle.
//    - stall_o sets when the count reaches stall_limit_p and stays set until reset_n_i=0.
//  - Undefined: no counter and no stall_o port; behaviour otherwise identical.
// TESTING
//  1. Reset, then v_i=2'b11 with single-beat packets, max_pkts_p=1, yumi_i=1 always
//     -> tag_o sequence 0,1,0,1.
//  2. Input 0 sends a 3-beat packet; v_i[1]=1 throughout -> tag_o=0 for 3 beats, then 1.
//     yumi_o[1]=0 during the packet.
//  3. max_pkts_p=2; both inputs stream single-beat packets -> tag_o sequence 0,0,1,1,0,0.
//  4. Mid-packet, v_i[owner]=0 for 2 cycles while the other input is valid -> v_o=0 for 2 cycles,
//     then the packet resumes on the same tag.
//  5. Reset asserted mid-packet on input 1, then released with v_i=2'b11 -> tag_o=0 first,
//     mid-packet lock gone.
//  6. With the watchdog macro, stall_limit_p=4: owner idle mid-packet for 4 cycles -> stall_o=1
//     from cycle 4; it stays 1 until reset.

Source files
------------

// File: rtl/bsg_round_robin_burst_n_to_1.sv
// rtl/bsg_round_robin_burst_n_to_1.sv - packet-aware round-robin N-to-1 arbiter/mux with burst tenure
// Optional stall watchdog: BSG_ROUND_ROBIN_BURST_STALL_WATCHDOG_EN (adds stall_limit_p and stall_o).
module bsg_round_robin_burst_n_to_1 #(
   parameter int width_p    = 16,
   parameter int num_in_p   = 2,
   parameter int max_pkts_p = 2,
`ifdef BSG_ROUND_ROBIN_BURST_STALL_WATCHDOG_EN
   parameter int stall_limit_p = 64,
`endif
   localparam int lg_in_lp = $clog2(num_in_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [num_in_p*width_p-1:0]  data_i,
   input  logic [num_in_p-1:0]          v_i,
   input  logic [num_in_p-1:0]          last_i,
   output logic [num_in_p-1:0]          yumi_o,
   output logic                         v_o,
   output logic [width_p-1:0]           data_o,
   output logic [lg_in_lp-1:0]          tag_o,
   output logic                         last_o,
   input  logic                         yumi_i
`ifdef BSG_ROUND_ROBIN_BURST_STALL_WATCHDOG_EN
   ,output logic                        stall_o
`endif
);

   localparam int pkts_w_lp = $clog2(max_pkts_p + 1);
   localparam logic [pkts_w_lp-1:0] max_pkts_lp = pkts_w_lp'(max_pkts_p);
   localparam logic [pkts_w_lp-1:0] one_pkt_lp  = pkts_w_lp'(1);

   logic [lg_in_lp-1:0]  owner_r;
   logic                 tenure_r;
   logic                 mid_pkt_r;
   logic [pkts_w_lp-1:0] pkts_r;

   logic [lg_in_lp-1:0]  rr_sel;
   logic                 rr_found;
   logic [lg_in_lp-1:0]  sel;
   logic                 hold_mode;
   logic                 rr_mode;
   logic                 new_tenure;
   logic                 handshake;

   // Circular scan starting just after the current owner, so the owner has lowest priority.
   always_comb begin
      logic [lg_in_lp-1:0] cand;
      rr_sel   = owner_r;
      rr_found = 1'b0;
      cand     = '0;
      for (int i = 1; i <= num_in_p; i++) begin
         cand = lg_in_lp'((int'(owner_r) + i) % num_in_p);
         if (!rr_found && v_i[cand]) begin
            rr_sel   = cand;
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      hold_mode  = ~mid_pkt_r & tenure_r & v_i[owner_r] & (pkts_r < max_pkts_lp);
      rr_mode    = ~mid_pkt_r & ~hold_mode;
      sel        = rr_mode ? rr_sel : owner_r;
      v_o        = mid_pkt_r ? v_i[owner_r] : (|v_i);
      data_o     = data_i[sel*width_p +: width_p];
      tag_o      = sel;
      last_o     = last_i[sel];
      yumi_o     = '0;
      yumi_o[sel] = yumi_i & v_o;
      handshake  = v_o & yumi_i;
      new_tenure = (sel != owner_r) | ~tenure_r | rr_mode;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         owner_r   <= lg_in_lp'(num_in_p - 1);
         tenure_r  <= 1'b0;
         mid_pkt_r <= 1'b0;
         pkts_r    <= '0;
      end else if (handshake) begin
         owner_r   <= sel;
         tenure_r  <= 1'b1;
         mid_pkt_r <= ~last_i[sel];
         if (last_i[sel]) begin
            if (new_tenure)
               pkts_r <= one_pkt_lp;
            else if (pkts_r >= max_pkts_lp)
               pkts_r <= max_pkts_lp;
            else
               pkts_r <= pkts_r + 1'b1;
         end else if (new_tenure) begin
            pkts_r <= '0;
         end
      end
   end

`ifdef BSG_ROUND_ROBIN_BURST_STALL_WATCHDOG_EN
   localparam int stall_w_lp = $clog2(stall_limit_p + 1);
   localparam logic [stall_w_lp-1:0] stall_lim_lp = stall_w_lp'(stall_limit_p);

   logic [stall_w_lp-1:0] stall_cnt_r;
   logic                  stall_r;
   logic                  stalling;

   assign stalling = mid_pkt_r & ~v_i[owner_r];
   assign stall_o  = stall_r;

   // Sticky flag: once the owner has starved the link long enough, only reset clears it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stall_cnt_r <= '0;
         stall_r     <= 1'b0;
      end else begin
         if (!stalling)
            stall_cnt_r <= '0;
         else if (stall_cnt_r != stall_lim_lp)
            stall_cnt_r <= stall_cnt_r + 1'b1;
         if (stalling && (stall_cnt_r == stall_lim_lp - 1'b1))
            stall_r <= 1'b1;
      end
   end
`endif

`ifndef SYNTHESIS
   yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif

endmodule
